// File: rtl/i2c_uart_framer.sv
// Record FIFO plus byte framer: START, address, mode, data bytes, optional checksum, STOP.
// Define I2C_UART_FRAMER_CHECKSUM_EN to insert an XOR checksum byte before STOP.
module i2c_uart_framer #(
    parameter int         MAX_BYTES  = 4,
    parameter int         FIFO_DEPTH = 4,
    parameter logic [7:0] START_BYTE = 8'hFF,
    parameter logic [7:0] STOP_BYTE  = 8'hFF
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   data_ready,
    input  logic [8*MAX_BYTES-1:0] toPC_data,
    input  logic [7:0]             toPC_mode,
    input  logic [7:0]             toPC_address,
    input  logic                   tx_done_tick,
    output logic                   tx_start,
    output logic [7:0]             data_byte,
    output logic                   tx_complete,
    output logic                   fifo_full,
    output logic                   overflow
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int DW = 8 * MAX_BYTES;

    typedef enum logic [2:0] {
        IDLE, START, ADDR, MODE, DATA,
`ifdef I2C_UART_FRAMER_CHECKSUM_EN
        CSUM,
`endif
        STOP, DONE
    } state_t;

    logic [DW-1:0] mem_data_q [FIFO_DEPTH];
    logic [7:0]    mem_mode_q [FIFO_DEPTH];
    logic [7:0]    mem_addr_q [FIFO_DEPTH];
    logic [AW:0]   wr_q, rd_q;
    logic          empty, pop, push;

    logic [DW-1:0] rec_data_q;
    logic [7:0]    rec_mode_q, rec_addr_q;

    state_t        state_q, state_d, tail_state;
    logic [3:0]    cnt_q, cnt_d, n_bytes;
    logic          tx_start_q, tx_start_d, cmpl_q, cmpl_d, ovf_q, advance;
    logic [7:0]    byte_q, byte_d, tail_byte;

    function automatic logic [3:0] frame_len(input logic [7:0] mode);
        logic [3:0] req;
        req = {1'b0, mode[4:2]} + 4'd1;
        if (mode[1])
            return 4'd0;
        else if (req > 4'(MAX_BYTES))
            return 4'(MAX_BYTES);
        else
            return req;
    endfunction

    function automatic logic [7:0] pick(input logic [DW-1:0] d, input logic [3:0] idx);
        logic [7:0] b;
        b = 8'h00;
        for (int i = 0; i < MAX_BYTES; i++)
            if (idx == 4'(i)) b = d[8*i +: 8];
        return b;
    endfunction

`ifdef I2C_UART_FRAMER_CHECKSUM_EN
    function automatic logic [7:0] csum(input logic [7:0] a, input logic [7:0] m,
                                        input logic [DW-1:0] d, input logic [3:0] n);
        logic [7:0] x;
        x = a ^ m;
        for (int i = 0; i < MAX_BYTES; i++)
            if (4'(i) < n) x = x ^ d[8*i +: 8];
        return x;
    endfunction
`endif

    // Extra MSB on the pointers distinguishes full from empty.
    assign empty     = (wr_q == rd_q);
    assign fifo_full = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign pop       = (state_q == IDLE) && !empty;
    assign push      = data_ready && (!fifo_full || pop);

    always_ff @(posedge clk) begin
        if (push) begin
            mem_data_q[wr_q[AW-1:0]] <= toPC_data;
            mem_mode_q[wr_q[AW-1:0]] <= toPC_mode;
            mem_addr_q[wr_q[AW-1:0]] <= toPC_address;
        end
        if (pop) begin
            rec_data_q <= mem_data_q[rd_q[AW-1:0]];
            rec_mode_q <= mem_mode_q[rd_q[AW-1:0]];
            rec_addr_q <= mem_addr_q[rd_q[AW-1:0]];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_q       <= '0;
            rd_q       <= '0;
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            tx_start_q <= 1'b1;
            byte_q     <= 8'h00;
            cmpl_q     <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            if (push) wr_q <= wr_q + 1'b1;
            if (pop)  rd_q <= rd_q + 1'b1;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            tx_start_q <= tx_start_d;
            byte_q     <= byte_d;
            cmpl_q     <= cmpl_d;
            ovf_q      <= ovf_q | (data_ready & ~push);
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        tx_start_d = 1'b1;
        byte_d     = byte_q;
        cmpl_d     = 1'b0;
        n_bytes    = frame_len(rec_mode_q);
        // A low tx_start marks the launch cycle, where the done tick is ignored.
        advance    = tx_start_q && tx_done_tick;
`ifdef I2C_UART_FRAMER_CHECKSUM_EN
        tail_state = CSUM;
        tail_byte  = csum(rec_addr_q, rec_mode_q, rec_data_q, n_bytes);
`else
        tail_state = STOP;
        tail_byte  = STOP_BYTE;
`endif
        case (state_q)
            IDLE: begin
                byte_d = 8'h00;
                if (pop) begin
                    state_d = START; byte_d = START_BYTE; tx_start_d = 1'b0;
                end
            end
            START: if (advance) begin
                state_d = ADDR; byte_d = rec_addr_q; tx_start_d = 1'b0;
            end
            ADDR: if (advance) begin
                state_d = MODE; byte_d = rec_mode_q; tx_start_d = 1'b0;
            end
            MODE: if (advance) begin
                tx_start_d = 1'b0;
                if (n_bytes != 4'd0) begin
                    state_d = DATA; cnt_d = 4'd0; byte_d = pick(rec_data_q, 4'd0);
                end else begin
                    state_d = tail_state; byte_d = tail_byte;
                end
            end
            DATA: if (advance) begin
                tx_start_d = 1'b0;
                if (cnt_q == n_bytes - 4'd1) begin
                    state_d = tail_state; byte_d = tail_byte; cnt_d = 4'd0;
                end else begin
                    cnt_d = cnt_q + 4'd1; byte_d = pick(rec_data_q, cnt_q + 4'd1);
                end
            end
`ifdef I2C_UART_FRAMER_CHECKSUM_EN
            CSUM: if (advance) begin
                state_d = STOP; byte_d = STOP_BYTE; tx_start_d = 1'b0;
            end
`endif
            STOP: if (advance) begin
                state_d = DONE; byte_d = 8'h00; cmpl_d = 1'b1;
            end
            DONE: begin
                state_d = IDLE; byte_d = 8'h00;
            end
            default: begin
                state_d = IDLE; byte_d = 8'h00;
            end
        endcase
    end

    assign tx_start    = tx_start_q;
    assign data_byte   = byte_q;
    assign tx_complete = cmpl_q;
    assign overflow    = ovf_q;

endmodule

// File: tb/tb_i2c_uart_framer.sv
// Scoreboard bench for i2c_uart_framer: a frame model queues expected bytes, a monitor checks them.
module tb_i2c_uart_framer;
    localparam int MB = 4;
    localparam int FD = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          data_ready = 1'b0;
    logic [8*MB-1:0] toPC_data = '0;
    logic [7:0]    toPC_mode = 8'h00;
    logic [7:0]    toPC_address = 8'h00;
    logic          tx_done_tick = 1'b0;
    logic          tx_start;
    logic [7:0]    data_byte;
    logic          tx_complete;
    logic          fifo_full;
    logic          overflow;

    i2c_uart_framer #(
        .MAX_BYTES(MB), .FIFO_DEPTH(FD), .START_BYTE(8'hFF), .STOP_BYTE(8'hFF)
    ) dut (
        .clk(clk), .reset(reset), .data_ready(data_ready), .toPC_data(toPC_data),
        .toPC_mode(toPC_mode), .toPC_address(toPC_address), .tx_done_tick(tx_done_tick),
        .tx_start(tx_start), .data_byte(data_byte), .tx_complete(tx_complete),
        .fifo_full(fifo_full), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [8:0] exp_q [$];
    int launches = 0;
    int completes = 0;
    int delay_cfg = 0;
    bit glitch_en = 0;
    bit spur_en = 0;
    bit active = 0;
    logic [7:0] hold_v = 8'h00;
    int cyc = 0;
    int last_cmpl_cyc = -1;
    bit b2b_chk = 0;
    bit pending = 0;
    int pend_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Expected byte stream of one accepted record; bit 8 marks the tx_complete pulse.
    task automatic model_frame(input logic [7:0] a, input logic [7:0] m, input logic [31:0] d);
        int n;
        logic [7:0] x;
        logic [7:0] b;
        n = int'(m[4:2]) + 1;
        if (n > MB) n = MB;
        if (m[1]) n = 0;
        exp_q.push_back({1'b0, 8'hFF});
        exp_q.push_back({1'b0, a});
        exp_q.push_back({1'b0, m});
        x = a ^ m;
        for (int i = 0; i < n; i++) begin
            b = d[8*i +: 8];
            exp_q.push_back({1'b0, b});
            x = x ^ b;
        end
`ifdef I2C_UART_FRAMER_CHECKSUM_EN
        exp_q.push_back({1'b0, x});
`endif
        exp_q.push_back({1'b0, 8'hFF});
        exp_q.push_back({1'b1, 8'h00});
    endtask

    task automatic push(input logic [7:0] a, input logic [7:0] m, input logic [31:0] d,
                        input bit accepted);
        data_ready   = 1'b1;
        toPC_address = a;
        toPC_mode    = m;
        toPC_data    = d;
        if (accepted) model_frame(a, m, d);
        @(negedge clk);
        data_ready = 1'b0;
    endtask

    task automatic wait_cmpl(input int target, input int budget);
        int k;
        k = 0;
        while (completes < target && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk("wait_complete", 32'(completes >= target), 32'd1);
    endtask

    task automatic wait_launch(input int target, input int budget);
        int k;
        k = 0;
        while (launches < target && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk("wait_launch", 32'(launches >= target), 32'd1);
    endtask

    // UART responder: one done tick per launched byte after a configurable wait.
    initial begin
        forever begin
            @(negedge clk);
            tx_done_tick = 1'b0;
            if (reset) begin
                pending = 0;
            end else if (!tx_start) begin
                pending  = 1;
                pend_cnt = (delay_cfg < 0) ? int'($urandom_range(0, 3)) : delay_cfg;
                if (glitch_en && $urandom_range(0, 1) == 1) tx_done_tick = 1'b1;
            end else if (pending) begin
                if (pend_cnt == 0) begin
                    tx_done_tick = 1'b1;
                    pending = 0;
                end else begin
                    pend_cnt--;
                end
            end else if (spur_en && $urandom_range(0, 3) == 0) begin
                tx_done_tick = 1'b1;
            end
        end
    end

    // Monitor: every launch and completion pulse pops the scoreboard.
    initial begin
        logic [8:0] e;
        forever begin
            @(negedge clk);
            cyc++;
            if (reset) begin
                active = 0;
            end else if (!tx_start) begin
                launches++;
                if (b2b_chk && last_cmpl_cyc >= 0) begin
                    chk("b2b_gap", 32'((cyc - last_cmpl_cyc) <= 2), 32'd1);
                    last_cmpl_cyc = -1;
                end
                chk("launch_no_cmpl", 32'(tx_complete), 32'd0);
                if (exp_q.size() == 0) begin
                    chk("unexpected_launch", 32'(data_byte), 32'h1FF);
                end else begin
                    e = exp_q.pop_front();
                    chk("byte", 32'({1'b0, data_byte}), 32'(e));
                end
                hold_v = data_byte;
                active = 1;
            end else if (tx_complete) begin
                completes++;
                if (b2b_chk) last_cmpl_cyc = cyc;
                if (exp_q.size() == 0) begin
                    chk("unexpected_complete", 32'(data_byte), 32'h1FF);
                end else begin
                    e = exp_q.pop_front();
                    chk("complete", 32'({1'b1, data_byte}), 32'(e));
                end
                active = 0;
            end else if (active) begin
                chk("hold", 32'(data_byte), 32'(hold_v));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int pushed;
        int base;
        int c0;
        int k;
        repeat (3) @(negedge clk);
        chk("rst_tx_start", 32'(tx_start), 32'd1);
        chk("rst_byte", 32'(data_byte), 32'd0);
        chk("rst_cmpl", 32'(tx_complete), 32'd0);
        chk("rst_full", 32'(fifo_full), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("idle_tx_start", 32'(tx_start), 32'd1);
            chk("idle_byte", 32'(data_byte), 32'd0);
            chk("idle_cmpl", 32'(tx_complete), 32'd0);
        end

        delay_cfg = 0;
        push(8'h48, 8'h08, 32'hD4C3B2A1, 1);
        wait_cmpl(1, 200);

        delay_cfg = 7;
        push(8'h3C, 8'h02, 32'h12345678, 1);
        wait_cmpl(2, 400);
        chk("drained_directed", 32'(exp_q.size()), 32'd0);
        pushed = 2;

        delay_cfg = -1;
        glitch_en = 1;
        spur_en = 1;
        for (int r = 0; r < 40; r++) begin
            k = 0;
            while ((pushed - completes) >= FD && k < 1000) begin
                @(negedge clk);
                k++;
            end
            repeat ($urandom_range(0, 3)) @(negedge clk);
            push(8'($urandom), 8'($urandom), $urandom, 1);
            pushed++;
        end
        wait_cmpl(pushed, 6000);
        glitch_en = 0;
        spur_en = 0;
        repeat (3) @(negedge clk);
        chk("ovf_before", 32'(overflow), 32'd0);

        delay_cfg = 30;
        base = launches;
        push(8'hA0, 8'h00, 32'h000000EE, 1);
        pushed++;
        wait_launch(base + 1, 50);
        for (int i = 0; i < 5; i++) begin
            push(8'hB0 + 8'(i), 8'h0C, $urandom, i < 4);
            if (i == 3) begin
                chk("full_after4", 32'(fifo_full), 32'd1);
                chk("ovf_after4", 32'(overflow), 32'd0);
            end
            if (i == 4) begin
                chk("full_after5", 32'(fifo_full), 32'd1);
                chk("ovf_after5", 32'(overflow), 32'd1);
            end
        end
        pushed += 4;
        b2b_chk = 1;
        delay_cfg = 0;
        wait_cmpl(pushed, 3000);
        b2b_chk = 0;
        last_cmpl_cyc = -1;
        chk("ovf_sticky", 32'(overflow), 32'd1);
        chk("full_drained", 32'(fifo_full), 32'd0);

        delay_cfg = 10;
        base = launches;
        push(8'h55, 8'h0C, 32'hCAFEBABE, 1);
        wait_launch(base + 4, 200);
        repeat (3) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_tx_start", 32'(tx_start), 32'd1);
        chk("mid_rst_byte", 32'(data_byte), 32'd0);
        chk("mid_rst_cmpl", 32'(tx_complete), 32'd0);
        chk("mid_rst_full", 32'(fifo_full), 32'd0);
        chk("mid_rst_ovf", 32'(overflow), 32'd0);
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_ovf", 32'(overflow), 32'd0);
        delay_cfg = 0;
        c0 = completes;
        push(8'h66, 8'h04, 32'h0BADF00D, 1);
        wait_cmpl(c0 + 1, 300);
        chk("drained_final", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
